// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and seven-segment code constants for the
//                digital-clock datapath.
//                Codes are active-low: bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

   typedef logic [7:0] seg_t;

   // What a seven-segment decoder should show.
   typedef enum logic [1:0] {
      SEL_DIGIT = 2'd0,
      SEL_A     = 2'd1,
      SEL_P     = 2'd2,
      SEL_BLANK = 2'd3
   } seg_sel_t;

   localparam seg_t SEG_0     = 8'hC0;
   localparam seg_t SEG_1     = 8'hF9;
   localparam seg_t SEG_2     = 8'hA4;
   localparam seg_t SEG_3     = 8'hB0;
   localparam seg_t SEG_4     = 8'h99;
   localparam seg_t SEG_5     = 8'h92;
   localparam seg_t SEG_6     = 8'h82;
   localparam seg_t SEG_7     = 8'hF8;
   localparam seg_t SEG_8     = 8'h80;
   localparam seg_t SEG_9     = 8'h90;
   localparam seg_t SEG_A     = 8'h88;
   localparam seg_t SEG_P     = 8'h8C;
   localparam seg_t SEG_BLANK = 8'hFF;

   // Active-low code for a decimal digit; non-decimal values show blank.
   function automatic seg_t digit_code(input logic [3:0] d);
      seg_t c;
      case (d)
         4'd0:    c = SEG_0;
         4'd1:    c = SEG_1;
         4'd2:    c = SEG_2;
         4'd3:    c = SEG_3;
         4'd4:    c = SEG_4;
         4'd5:    c = SEG_5;
         4'd6:    c = SEG_6;
         4'd7:    c = SEG_7;
         4'd8:    c = SEG_8;
         4'd9:    c = SEG_9;
         default: c = SEG_BLANK;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Seven-segment decoder for a decimal digit or the letters
//                A / P / blank.
//  Ports       : digit  in  4  decimal digit (used when sel = SEL_DIGIT)
//                sel    in  2  digit / A / P / blank select
//                seg    out 8  segment code (dp,g,f,e,d,c,b,a)
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decoder
   import clock_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit,
   input  seg_sel_t   sel,
   output seg_t       seg
);

   seg_t code;

   always_comb begin
      code = SEG_BLANK;
      case (sel)
         SEL_DIGIT: code = digit_code(digit);
         SEL_A:     code = SEG_A;
         SEL_P:     code = SEG_P;
         SEL_BLANK: code = SEG_BLANK;
         default:   code = SEG_BLANK;
      endcase
   end

   // Codes are native active-low; invert for active-high displays.
   assign seg = ACTIVE_LOW ? code : ~code;

endmodule
`default_nettype wire

// File: rtl/hour_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hour_counter
//  Description : 12-hour hour counter (1..12) with AM/PM flag, advancing one
//                hour per enabled clock. Outputs are seven-segment codes
//                decoded combinationally from the state registers.
//  Ports       : clk    in  1  system clock (rising edge)
//                rst    in  1  synchronous active-high reset -> 12 AM
//                enb    in  1  advance one hour on this edge
//                h0     out 8  hour ones digit segments
//                h1     out 8  hour tens digit segments
//                am_pm  out 8  "A" / "P" segments
//  Revision    : 1.0  initial release
// ============================================================================
module hour_counter
   import clock_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW     = 1'b1,
   parameter bit BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   output logic [7:0] h0,
   output logic [7:0] h1,
   output logic [7:0] am_pm
);

   logic [3:0] hour_ones;
   logic       hour_tens;
   logic       pm;

   always_ff @(posedge clk) begin
      if (rst) begin
         hour_tens <= 1'b1;
         hour_ones <= 4'd2;
         pm        <= 1'b0;
      end else if (enb) begin
         if (hour_tens && hour_ones == 4'd2) begin
            // 12 -> 1
            hour_tens <= 1'b0;
            hour_ones <= 4'd1;
         end else if (hour_tens && hour_ones == 4'd1) begin
            // 11 -> 12 is the only step that flips AM/PM
            hour_ones <= 4'd2;
            pm        <= ~pm;
         end else if (hour_ones >= 4'd9) begin
            // 9 -> 10; the >= also pulls any out-of-range ones value back
            hour_tens <= 1'b1;
            hour_ones <= 4'd0;
         end else begin
            hour_ones <= hour_ones + 4'd1;
         end
      end
   end

   seg_sel_t h1_sel;
   seg_sel_t ap_sel;

   assign h1_sel = (hour_tens || !BLANK_LEADING_ZERO) ? SEL_DIGIT : SEL_BLANK;
   assign ap_sel = pm ? SEL_P : SEL_A;

   seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_h0 (
      .digit (hour_ones),
      .sel   (SEL_DIGIT),
      .seg   (h0)
   );

   seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_h1 (
      .digit ({3'b000, hour_tens}),
      .sel   (h1_sel),
      .seg   (h1)
   );

   seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_ap (
      .digit (4'd0),
      .sel   (ap_sel),
      .seg   (am_pm)
   );

endmodule
`default_nettype wire

// File: tb/tb_hour_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hour_counter
//  Description : Self-checking bench for hour_counter. A default-parameter
//                instance and an inverted/leading-zero instance share stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hour_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enb = 1'b0;
   logic [7:0] h0, h1, am_pm;
   logic [7:0] h0_b, h1_b, am_pm_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hour_counter #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .enb(enb), .h0(h0), .h1(h1), .am_pm(am_pm)
   );

   hour_counter #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) dut_b (
      .clk(clk), .rst(rst), .enb(enb), .h0(h0_b), .h1(h1_b), .am_pm(am_pm_b)
   );

   typedef struct {
      logic       rst;
      logic       enb;
      logic [7:0] h1;
      logic [7:0] h0;
      logic [7:0] ap;
      string      name;
   } vec_t;

   vec_t vecs[$];

   logic [7:0] digits [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Drive one cycle, then compare both instances 1 ns after the edge.
   task automatic step(input logic r, input logic e, input logic [7:0] eh1,
                       input logic [7:0] eh0, input logic [7:0] eap, input string name);
      rst = r;
      enb = e;
      @(posedge clk);
      #1;
      cmp({name, " h1"}, h1, eh1);
      cmp({name, " h0"}, h0, eh0);
      cmp({name, " am_pm"}, am_pm, eap);
      // Second instance: inverted polarity, tens shows "0" instead of blank
      cmp({name, " h1_inv"}, h1_b, ~((eh1 == 8'hFF) ? 8'hC0 : eh1));
      cmp({name, " h0_inv"}, h0_b, ~eh0);
      cmp({name, " am_pm_inv"}, am_pm_b, ~eap);
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic [7:0] eh1,
                               input logic [7:0] eh0, input logic [7:0] eap, input string n);
      vec_t v;
      v.rst = r; v.enb = e; v.h1 = eh1; v.h0 = eh0; v.ap = eap; v.name = n;
      return v;
   endfunction

   initial begin
      // ---- table: reset hold then 25 enabled steps from 12 AM ----
      vecs.push_back(mk(1'b1, 1'b1, 8'hF9, 8'hA4, 8'h88, "reset0"));
      vecs.push_back(mk(1'b1, 1'b1, 8'hF9, 8'hA4, 8'h88, "reset1"));
      for (int k = 1; k <= 25; k++) begin
         int hr;
         int is_pm;
         hr    = ((11 + k) % 12) + 1;     // hour reached after k steps from 12
         is_pm = (k / 12) % 2;            // flips on reaching 12 at k=12, 24
         vecs.push_back(mk(1'b0, 1'b1,
                           (hr >= 10) ? 8'hF9 : 8'hFF,
                           digits[hr % 10],
                           is_pm ? 8'h8C : 8'h88,
                           $sformatf("step%0d", k)));
      end

      // Spot checks against literal values from hand calculation
      if (vecs[2].h0 != 8'hF9 || vecs[11].h1 != 8'hF9 || vecs[11].h0 != 8'hC0 ||
          vecs[13].ap != 8'h8C || vecs[25].ap != 8'h88) begin
         $display("FAIL table_build: vector table inconsistent (%02h)", vecs[13].ap);
         errors++;
      end

      @(negedge clk);
      foreach (vecs[i])
         step(vecs[i].rst, vecs[i].enb, vecs[i].h1, vecs[i].h0, vecs[i].ap, vecs[i].name);

      // ---- hold at 7 PM: now 1 AM; 11 steps to 12 PM, 7 more to 7 PM ----
      repeat (18) begin
         rst = 1'b0; enb = 1'b1;
         @(posedge clk);
      end
      #1;
      cmp("at_7pm h0", h0, 8'hF8);
      cmp("at_7pm am_pm", am_pm, 8'h8C);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 8'hFF, 8'hF8, 8'h8C, $sformatf("hold%0d", i));
      step(1'b0, 1'b1, 8'hFF, 8'h80, 8'h8C, "reenable_8pm");

      // ---- enb=0 must not block reset ----
      step(1'b1, 1'b0, 8'hF9, 8'hA4, 8'h88, "rst_no_enb");

      // ---- reset mid-count at 5 PM with enb=1 ----
      repeat (17) begin
         rst = 1'b0; enb = 1'b1;
         @(posedge clk);
      end
      #1;
      cmp("at_5pm h0", h0, 8'h92);
      cmp("at_5pm am_pm", am_pm, 8'h8C);
      step(1'b1, 1'b1, 8'hF9, 8'hA4, 8'h88, "rst_at_5pm");
      step(1'b0, 1'b1, 8'hFF, 8'hF9, 8'h88, "resume_1am");
      step(1'b0, 1'b1, 8'hFF, 8'hA4, 8'h88, "resume_2am");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
